// File: rtl/arb_pkg.sv
// arb_pkg: FSM state and owner encodings shared by the memory arbiter files
package arb_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_t;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_LDR  = 2'b10;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: combinational 2-way round-robin picker; bit0 = CPU, bit1 = loader
module arb_rr2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  always_comb gnt_o = &req_i ? (last_i ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: CPU/loader arbiter for a single-port synchronous memory.
// Define ARB_LOCK_EN to add ldr_lock, letting the loader keep ownership across transactions.
module arbitro_memoria
  import arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
`ifdef ARB_LOCK_EN
  input  logic              ldr_lock,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_q,
  output logic [1:0]        owner
);
  state_t            state_q;
  logic              last_q, lock_q, we_q, cpu_ack_q, ldr_ack_q, mem_we_q, lock_d;
  logic [1:0]        owner_q, gnt_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q, cpu_rdata_q, ldr_rdata_q;
`ifdef ARB_LOCK_EN
  assign lock_d = ldr_lock;
`else
  assign lock_d = 1'b0;
`endif
  // a held lock masks the CPU so only the loader can be granted
  arb_rr2 u_rr (.req_i({ldr_req, cpu_req & ~lock_q}), .last_i(last_q), .gnt_o(gnt_d));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      lock_q      <= 1'b0;
      we_q        <= 1'b0;
      owner_q     <= OWN_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      cpu_ack_q   <= 1'b0;
      ldr_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
      case (state_q)
        S_IDLE: if (|gnt_d) begin
          state_q    <= S_ACCESS;
          owner_q    <= gnt_d[1] ? OWN_LDR : OWN_CPU;
          we_q       <= gnt_d[1] ? ldr_we : cpu_we;
          mem_we_q   <= gnt_d[1] ? ldr_we : cpu_we;
          mem_addr_q <= gnt_d[1] ? ldr_addr : cpu_addr;
          mem_data_q <= gnt_d[1] ? ldr_wdata : cpu_wdata;
        end
        S_ACCESS: begin
          mem_we_q <= 1'b0;
          state_q  <= S_RESP;
        end
        S_RESP: begin
          cpu_ack_q   <= ~owner_q[1];
          ldr_ack_q   <= owner_q[1];
          cpu_rdata_q <= (!owner_q[1] && !we_q) ? mem_q : '0;
          ldr_rdata_q <= (owner_q[1] && !we_q) ? mem_q : '0;
          last_q      <= owner_q[1];
          lock_q      <= owner_q[1] & lock_d;
          owner_q     <= (owner_q[1] & lock_d) ? OWN_LDR : OWN_NONE;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign cpu_ack   = cpu_ack_q;
  assign ldr_ack   = ldr_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_we    = mem_we_q;
  assign owner     = owner_q;
endmodule

// File: tb/tb_arbitro_memoria.sv
// tb_arbitro_memoria: directed and random transactions checked against a round-robin reference model
module tb_arbitro_memoria;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, ldr_addr = '0, ldr_wdata = '0;
  logic        cpu_ack, ldr_ack, mem_we;
  logic [15:0] cpu_rdata, ldr_rdata, mem_addr, mem_data, mem_q;
  logic [1:0]  owner;
  logic [15:0] mem [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] last_rd;
  int          errors = 0, checks = 0, last_w = 2;
  logic        lock_m = 1'b0;

  arbitro_memoria dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
`ifdef ARB_LOCK_EN
    .ldr_lock(ldr_lock),
`endif
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q), .owner(owner)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic raise_cpu(input logic we, input logic [15:0] a, input logic [15:0] d);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
  endtask

  task automatic raise_ldr(input logic we, input logic [15:0] a, input logic [15:0] d);
    ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1;
  endtask

  // one full transaction from the next sampling edge; winner follows round-robin/lock rules
  task automatic xact();
    int w;
    logic we, lk;
    logic [15:0] a, d, rd;
    w  = lock_m ? 2 : (cpu_req && ldr_req) ? (last_w == 2 ? 1 : 2) : (cpu_req ? 1 : 2);
    we = (w == 1) ? cpu_we : ldr_we;
    a  = (w == 1) ? cpu_addr : ldr_addr;
    d  = (w == 1) ? cpu_wdata : ldr_wdata;
    rd = we ? 16'h0 : ref_mem[a];
    @(posedge clk); @(negedge clk);
    chk("grant_owner", 32'(owner), 32'(w));
    chk("ack_prev_low", 32'({cpu_ack, ldr_ack}), 32'(0));
    chk("mem_we_access", 32'(mem_we), 32'(we));
    chk("mem_addr", 32'(mem_addr), 32'(a));
    if (we) chk("mem_data", 32'(mem_data), 32'(d));
    @(posedge clk); @(negedge clk);
    chk("mem_we_pulse", 32'(mem_we), 32'(0));
    chk("ack_early", 32'({cpu_ack, ldr_ack}), 32'(0));
`ifdef ARB_LOCK_EN
    lk = (w == 2) && ldr_lock;
`else
    lk = 1'b0;
`endif
    @(posedge clk); @(negedge clk);
    chk("cpu_ack", 32'(cpu_ack), 32'(w == 1));
    chk("ldr_ack", 32'(ldr_ack), 32'(w == 2));
    chk("cpu_rdata", 32'(cpu_rdata), 32'((w == 1) ? rd : 16'h0));
    chk("ldr_rdata", 32'(ldr_rdata), 32'((w == 2) ? rd : 16'h0));
    chk("owner_release", 32'(owner), 32'(lk ? 2 : 0));
    last_rd = (w == 1) ? cpu_rdata : ldr_rdata;
    if (we) ref_mem[a] = d;
    last_w = w;
    lock_m = lk;
    if (w == 1) cpu_req = 1'b0; else ldr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", 32'({cpu_ack, ldr_ack, mem_we, owner}), 32'(0));
    chk("rst_data", 32'(cpu_rdata | ldr_rdata | mem_addr | mem_data), 32'(0));
    rst = 1'b0;
    // CPU write then read back
    raise_cpu(1'b1, 16'h0010, 16'h1234); xact();
    raise_cpu(1'b0, 16'h0010, 16'h0000); xact();
    chk("t1_readback", 32'(last_rd), 32'h1234);
    // loader at the top address
    raise_ldr(1'b1, 16'hFFFF, 16'hBEEF); xact();
    raise_ldr(1'b0, 16'hFFFF, 16'h0000); xact();
    chk("t6_readback", 32'(last_rd), 32'hBEEF);
    // reset lands while a loader write is in ACCESS
    raise_ldr(1'b1, 16'h0005, 16'h5555);
    @(posedge clk);
    #2;
    chk("t4_we_before", 32'(mem_we), 32'(1));
    rst = 1'b1;
    #1;
    chk("t4_we_async", 32'(mem_we), 32'(0));
    chk("t4_owner", 32'(owner), 32'(0));
    ldr_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_w = 2;
    lock_m = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t4_no_ack", 32'({ldr_ack, cpu_ack}), 32'(0));
    end
    chk("t4_write_lost", 32'(mem[16'h0005]), 32'(ref_mem[16'h0005]));
    // simultaneous requests after reset: CPU first
    raise_cpu(1'b1, 16'h0030, 16'hC0DE);
    raise_ldr(1'b1, 16'h0031, 16'hD00D);
    xact(); xact();
    // both held continuously
    for (int i = 0; i < 4; i++) begin
      if (!cpu_req) raise_cpu(1'b1, 16'h0040, 16'(i));
      if (!ldr_req) raise_ldr(1'b1, 16'h0041, 16'(i + 100));
      xact();
    end
    if (cpu_req || ldr_req) xact();
    // random mix
    for (int i = 0; i < 30; i++) begin
      if (!cpu_req && $urandom_range(1)) raise_cpu(1'($urandom), 16'($urandom_range(7)), 16'($urandom));
      if (!ldr_req && $urandom_range(1)) raise_ldr(1'($urandom), 16'($urandom_range(7)), 16'($urandom));
      if (!cpu_req && !ldr_req) raise_cpu(1'b0, 16'($urandom_range(7)), 16'h0);
      xact();
    end
    if (cpu_req || ldr_req) xact();
    if (cpu_req || ldr_req) xact();
`ifdef ARB_LOCK_EN
    // locked loader burst blocks a waiting CPU until lock drops
    ldr_lock = 1'b1;
    raise_ldr(1'b1, 16'h0000, 16'hA000); xact();
    raise_cpu(1'b0, 16'h0002, 16'h0000);
    for (int i = 1; i < 4; i++) begin
      ldr_lock = (i < 3);
      raise_ldr(1'b1, 16'(i), 16'(16'hA000 + i));
      xact();
    end
    ldr_lock = 1'b0;
    xact();
    chk("t5_cpu_read", 32'(last_rd), 32'hA002);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
